// File: rtl/if_id_buffer_pkg.sv
// Shared fetch-path constants used by the IF/ID buffer, the ID stage and the hazard unit.
package if_id_buffer_pkg;

  // Default width of pc and instruction words.
  localparam int WORD_BITWIDTH = 32;

  // Bubble instruction: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : if_id_buffer_pkg

// File: rtl/if_id_buffer_fetch_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push, pop, clear, count, full and empty.
// Storage resets to RESET_DATA so an idle head reads as a known value.
module fetch_fifo #(
  parameter int          DEPTH      = 2,
  parameter int          WIDTH      = 64,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  localparam int         PTR_W      = $clog2(DEPTH),
  localparam int         CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for pointers, count and storage; clear overrides push/pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is reset deliberately so the head reads RESET_DATA, not X, after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_DATA;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the same pre-edge values.
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule : fetch_fifo

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register built as a small in-order queue of fetched (pc, instr) pairs.
// Applies the flush/stall policy, raises hold_pc to back-pressure IF, and presents a
// NOP bubble whenever the queue is empty.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int                       WORD_BITWIDTH = if_id_buffer_pkg::WORD_BITWIDTH,
  parameter int                       DEPTH         = 2,
  parameter logic [WORD_BITWIDTH-1:0] NOP_INSTR     = WORD_BITWIDTH'(if_id_buffer_pkg::NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [WORD_BITWIDTH-1:0] pc,
  input  logic [WORD_BITWIDTH-1:0] fetch_instr,
  input  logic                     id_stall,
  input  logic                     flush,
  output logic                     hold_pc,
  output logic                     if_id_valid,
  output logic [WORD_BITWIDTH-1:0] if_id_pc,
  output logic [WORD_BITWIDTH-1:0] if_id_instr
);

  localparam int ENTRY_W = 2 * WORD_BITWIDTH;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;

  // Queue control: flush dominates, a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    pop     = (count != '0) && !id_stall && !flush;
    push    = fetch_valid && !flush && (!full || pop);
    hold_pc = fetch_valid && !flush && full && !pop;
  end

  fetch_fifo #(
    .DEPTH      (DEPTH),
    .WIDTH      (ENTRY_W),
    .RESET_DATA ({{WORD_BITWIDTH{1'b0}}, NOP_INSTR})
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata ({pc, fetch_instr}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Output mux: head entry when present, otherwise the empty bubble.
  always_comb begin
    if (empty) begin
      if_id_valid = 1'b0;
      if_id_pc    = '0;
      if_id_instr = NOP_INSTR;
    end else begin
      if_id_valid = 1'b1;
      if_id_pc    = head[ENTRY_W-1:WORD_BITWIDTH];
      if_id_instr = head[WORD_BITWIDTH-1:0];
    end
  end

endmodule : if_id_buffer

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed vector table, hand-written reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_if_id_buffer;

  localparam int          W     = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_valid;
  logic [W-1:0] pc;
  logic [W-1:0] fetch_instr;
  logic         id_stall;
  logic         flush;
  logic         hold_pc;
  logic         if_id_valid;
  logic [W-1:0] if_id_pc;
  logic [W-1:0] if_id_instr;

  int n_cmp  = 0;
  int n_fail = 0;

  if_id_buffer #(.WORD_BITWIDTH(W), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .pc          (pc),
    .fetch_instr (fetch_instr),
    .id_stall    (id_stall),
    .flush       (flush),
    .hold_pc     (hold_pc),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
  );

  always #5 clk = ~clk;

  // Instruction word the fake imem returns for a given pc.
  function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
    return a ^ 32'hA5C3_0000 ^ {a[15:0], 16'h0};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [W-1:0] a, input logic st, input logic fl);
    fetch_valid = fv;
    pc          = a;
    fetch_instr = instr_of(a);
    id_stall    = st;
    flush       = fl;
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [W-1:0] a);
    check({tag, "_valid"}, W'(if_id_valid), W'(v));
    check({tag, "_pc"},    if_id_pc,        v ? a : '0);
    check({tag, "_instr"}, if_id_instr,     v ? instr_of(a) : NOP);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic         fv;
    logic [W-1:0] a;
    logic         st;
    logic         fl;
    logic         exp_hold;   // during the cycle, before the edge
    logic         exp_valid;  // after the edge
    logic [W-1:0] exp_pc;     // after the edge
  } vec_t;

  vec_t vecs[$];

  // Reference model: queue of pcs (instructions are derived from pc).
  logic [W-1:0] model_q[$];

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // ---- Reset state ----
    do_reset();
    #1;
    check_outputs("reset", 1'b0, '0);
    check("reset_hold", W'(hold_pc), 0);

    // ---- Directed table ----
    //            fv    pc     stall flush hold  valid pc
    // streaming fetches, one-cycle latency
    vecs.push_back('{1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h4,  1'b0, 1'b0, 1'b0, 1'b1, 32'h4});
    vecs.push_back('{1'b1, 32'h8,  1'b0, 1'b0, 1'b0, 1'b1, 32'h8});
    vecs.push_back('{1'b0, 32'hC,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    // stall fills the queue, then hold_pc keeps pc=8 at IF
    vecs.push_back('{1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h4,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h8,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0});
    // release: simultaneous push/pop at full, no hold
    vecs.push_back('{1'b1, 32'h8,  1'b0, 1'b0, 1'b0, 1'b1, 32'h4});
    vecs.push_back('{1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 1'b1, 32'h8});
    vecs.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC});
    vecs.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    // queue holding 4,8 then flush with a fetch of 12 (dropped)
    vecs.push_back('{1'b1, 32'h4,  1'b1, 1'b0, 1'b0, 1'b1, 32'h4});
    vecs.push_back('{1'b1, 32'h8,  1'b1, 1'b0, 1'b0, 1'b1, 32'h4});
    vecs.push_back('{1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40});
    // flush together with stall while full: flush wins
    vecs.push_back('{1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40});
    vecs.push_back('{1'b1, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b1, 32'h50});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fv, vecs[i].a, vecs[i].st, vecs[i].fl);
      #1;
      check($sformatf("vec%0d_hold", i), W'(hold_pc), W'(vecs[i].exp_hold));
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // ---- Asynchronous reset mid-stream with count=2 ----
    @(negedge clk);
    drive(1'b1, 32'h60, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'h64, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("prereset", 1'b1, 32'h50);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, '0);
    check("async_rst_hold", W'(hold_pc), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    #1;
    check("resume_hold", W'(hold_pc), 0);
    @(posedge clk);
    #1;
    check_outputs("resume", 1'b1, 32'h100);

    // ---- Randomized traffic against the queue model ----
    do_reset();
    model_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic         r_fv, r_st, r_fl, m_pop, m_push, m_hold;
      logic [W-1:0] r_pc;
      r_fv = ($urandom_range(0, 9) < 7);
      r_st = ($urandom_range(0, 9) < 4);
      r_fl = ($urandom_range(0, 19) == 0);
      r_pc = {$urandom_range(0, 32'hFFFF), 2'b00};

      @(negedge clk);
      drive(r_fv, r_pc, r_st, r_fl);
      #1;
      m_pop  = (model_q.size() > 0) && !r_st && !r_fl;
      m_hold = r_fv && !r_fl && (model_q.size() == DEPTH) && !m_pop;
      m_push = r_fv && !r_fl && !m_hold;
      check("rnd_hold", W'(hold_pc), W'(m_hold));
      if (model_q.size() > 0) check_outputs("rnd_pre", 1'b1, model_q[0]);
      else                    check_outputs("rnd_pre", 1'b0, '0);

      @(posedge clk);
      if (r_fl) model_q.delete();
      else begin
        if (m_pop)  void'(model_q.pop_front());
        if (m_push) model_q.push_back(r_pc);
      end
    end
    #1;
    if (model_q.size() > 0) check_outputs("rnd_end", 1'b1, model_q[0]);
    else                    check_outputs("rnd_end", 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_if_id_buffer

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
Receiving end of the fetch interface. Captures each fetched (pc, instruction) pair produced by the IF stage and instruction memory into a small in-order queue. Presents the oldest entry to ID as the IF/ID pipeline register. Returns if_id_pc to IF for branch-target computation, and a hold_pc back-pressure signal that drives IF's hz_PCWrite.

Parameters:
WORD_BITWIDTH, 32, width of pc and instruction words
DEPTH, 2, queue entries; power of two, >= 2
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) presented when empty or flushed

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
fetch_valid  input  1  pc/fetch_instr hold a real fetch this cycle
pc  input  WORD_BITWIDTH  address of current fetch (from IF)
fetch_instr  input  WORD_BITWIDTH  instruction read at pc (combinational imem output)
id_stall  input  1  ID cannot accept the head entry this cycle
flush  input  1  taken branch (PCSrc); discard all queued and incoming entries
hold_pc  output  1  tells IF to keep pc (drives hz_PCWrite)
if_id_valid  output  1  head entry present
if_id_pc  output  WORD_BITWIDTH  pc of head entry
if_id_instr  output  WORD_BITWIDTH  instruction of head entry

Behaviour:
- State: DEPTH-entry storage (pc, instr), rd_ptr, wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH).
- Reset (async): count=0, rd_ptr=wr_ptr=0, storage cleared to pc=0 and instr=NOP_INSTR.
- Reset outputs: if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, hold_pc=0.
- pop = (count>0) && !id_stall && !flush.
- push = fetch_valid && !flush && ((count<DEPTH) || pop).
- hold_pc (combinational) = fetch_valid && !flush && (count==DEPTH) && !pop.
  - IF re-presents the same pc next cycle, so a fetch is never lost.
- Latency: a pair pushed at edge N is visible on the outputs after edge N if the queue was empty (1-cycle, register-like).
- Outputs are driven from storage[rd_ptr] when count>0. When count==0: if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR.
- Simultaneous push and pop: count unchanged, both pointers advance. Permitted at full; no hold_pc is asserted.
- Push only: count+1, wr_ptr+1. Pop only: count-1, rd_ptr+1.
- flush:
  - Has highest priority.
  - At the next edge: count=0 and rd_ptr=wr_ptr=0.
  - The fetch presented in the same cycle is dropped.
  - hold_pc=0 so that IF loads the branch target.
  - Next cycle the outputs show the empty bubble.
- flush together with id_stall: flush wins.
- fetch_valid=0: no push and hold_pc=0. Pops still occur.
- count never exceeds DEPTH and never underflows; pointer wrap is silent.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

Decomposition:
- Shared package: WORD_BITWIDTH default and the NOP_INSTR constant, both also used by the ID stage and hazard unit.
- One natural sub-module: fetch_fifo, a generic DEPTH x (2*WORD_BITWIDTH) synchronous FIFO with push, pop, clear, count, full and empty.
- if_id_buffer adds the flush/stall policy, the hold_pc logic and the empty-bubble output mux.

Test Plan:
1. Reset, then fetch_valid=1 with pc 0,4,8 and id_stall=0 -> if_id_pc follows 0,4,8 one cycle later, if_id_valid=1, hold_pc=0 throughout.
2. id_stall=1 for 3 cycles while fetching 0,4,8,12 -> count reaches 2 holding pc 0,4. hold_pc=1 while pc=8 is presented. if_id_pc stays 0. After release, output order is 0,4,8,12 with none lost or duplicated.
3. Full queue, id_stall=0, fetch pc=8 -> simultaneous push/pop, count stays 2, hold_pc=0.
4. Queue holding pc 4,8 with flush=1 and fetch pc=12 -> next cycle if_id_valid=0, if_id_instr=32'h00000013, hold_pc=0. Then fetch pc=0x40 appears as the head.
5. flush=1 and id_stall=1 together -> queue cleared anyway.
6. Assert rst mid-stream with count=2, without a clock edge -> outputs immediately valid=0, pc=0, instr=NOP. After deassert, normal fetch resumes from the next presented pc.
